pipe_stage_buf: RTL

//  Parametrised elastic pipeline-stage register, successor to the fixed IF_ID latch.

---
 rtl/cpu_pipe_pkg.sv | 26 ++
 rtl/pipe_sat_cnt.sv | 30 +++
 rtl/pipe_stage_buf.sv | 114 +++++++++++
 3 files changed

// File: rtl/cpu_pipe_pkg.sv
// ============================================================================
// cpu_pipe_pkg : shared widths and helpers for CPU pipeline-stage buffers
// Revision     : 1.0
// ============================================================================
`default_nettype none

package cpu_pipe_pkg;

  localparam int PC_W      = 32;
  localparam int INST_W    = 32;
  localparam int IFID_W    = PC_W + INST_W;
  localparam int DEF_CNT_W = 16;

  // Ceiling log2, usable in constant expressions (clog2(1) = 0).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_sat_cnt.sv
// ============================================================================
// pipe_sat_cnt : enable-driven up-counter that sticks at all-ones
// Revision     : 1.0
// ============================================================================
`default_nettype none

module pipe_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_buf.sv
// ============================================================================
// pipe_stage_buf : elastic DEPTH-entry pipeline register with stall/flush
// Revision       : 1.0
// ============================================================================
`default_nettype none

module pipe_stage_buf
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W = IFID_W,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic [DATA_W-1:0]           data_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [DATA_W-1:0]           data_o,
  input  logic                        stall_i,
  input  logic                        flush_i,
  output logic [clog2(DEPTH+1)-1:0]   count_o,
  output logic [CNT_W-1:0]            stall_cnt_o,
  output logic [CNT_W-1:0]            bubble_cnt_o
);

  localparam int OCC_W = clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;

  localparam logic [PTR_W-1:0] C_LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] C_FULL     = OCC_W'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [OCC_W-1:0]  r_count;

  logic              w_full;
  logic              w_empty;
  logic              w_ready;
  logic              w_valid;
  logic              w_push;
  logic              w_pop;
  logic [PTR_W-1:0]  w_rd_ptr_nxt;
  logic [PTR_W-1:0]  w_wr_ptr_nxt;
  logic              w_bubble;

  assign w_full  = (r_count == C_FULL);
  assign w_empty = (r_count == '0);

  // Handshake depends only on local state and control, never on ready_i.
  assign w_ready = !w_full  && !stall_i && !flush_i;
  assign w_valid = !w_empty && !stall_i && !flush_i;
  assign w_push  = valid_i && w_ready;
  assign w_pop   = w_valid && ready_i;

  // Explicit wrap keeps non-power-of-2 depths correct.
  assign w_rd_ptr_nxt = (r_rd_ptr == C_LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
  assign w_wr_ptr_nxt = (r_wr_ptr == C_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= data_i;
        r_wr_ptr        <= w_wr_ptr_nxt;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_nxt;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign ready_o = w_ready;
  assign valid_o = w_valid;
  assign data_o  = r_mem[r_rd_ptr];
  assign count_o = r_count;

  assign w_bubble = ready_i && !w_valid;

  pipe_sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .i_en  (stall_i),
    .o_cnt (stall_cnt_o)
  );

  pipe_sat_cnt #(.W(CNT_W)) u_bubble_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .i_en  (w_bubble),
    .o_cnt (bubble_cnt_o)
  );

endmodule

`default_nettype wire
